// File: rtl/clause_mem_banked.sv
// Clause/include word store: one masked write port, NUM_RD synchronous read
// channels with write-first collision handling, and a full-array clear engine.
module clause_mem_banked #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 256,
  parameter int SEG_WIDTH     = 32,
  parameter int NUM_RD        = 2,
  parameter int READ_REG      = 0,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                             clka,
  input  logic                             reset,
  input  logic                             clr_req,
  output logic                             clr_busy,
  input  logic                             ena,
  input  logic                             wea,
  input  logic [ADDR_WIDTH-1:0]            addra,
  input  logic [DATA_WIDTH-1:0]            dina,
  input  logic [DATA_WIDTH/SEG_WIDTH-1:0]  wmask,
  input  logic [NUM_RD-1:0]                enb,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]     addrb,
  output logic [NUM_RD*DATA_WIDTH-1:0]     doutb,
  output logic [NUM_RD-1:0]                validb
);

  localparam int NSEG  = DATA_WIDTH / SEG_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic                  init_pend_q;
  logic                  clr_busy_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  idle;
  logic                  wr_en;
  logic                  clr_last;
  logic                  clr_wr;
  logic [DATA_WIDTH-1:0] bit_mask;
  logic [DATA_WIDTH-1:0] wr_word_d;

  function automatic logic [DATA_WIDTH-1:0] expand_mask(input logic [NSEG-1:0] m);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < NSEG; k++) begin
      r[k*SEG_WIDTH +: SEG_WIDTH] = {SEG_WIDTH{m[k]}};
    end
    return r;
  endfunction

  assign idle      = (state_q == ST_IDLE);
  assign wr_en     = idle & ena & wea;
  assign clr_last  = (cnt_q[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}});
  assign clr_wr    = (state_q == ST_CLEAR) & ~cnt_q[ADDR_WIDTH];
  assign bit_mask  = expand_mask(wmask);
  // Merged word is both what gets stored and what a colliding read returns.
  assign wr_word_d = (mem[addra] & ~bit_mask) | (dina & bit_mask);
  assign clr_busy  = clr_busy_q;

  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      clr_busy_q  <= 1'b0;
      init_pend_q <= (INIT_ON_RESET != 0);
    end else begin
      init_pend_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (clr_req || init_pend_q) begin
          state_q    <= ST_CLEAR;
          clr_busy_q <= 1'b1;
          cnt_q      <= '0;
        end
      end else begin
        if (clr_last) begin
          state_q    <= ST_IDLE;
          clr_busy_q <= 1'b0;
          cnt_q      <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clka) begin
    if (clr_wr) begin
      mem[cnt_q[ADDR_WIDTH-1:0]] <= '0;
    end else if (wr_en) begin
      mem[addra] <= wr_word_d;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rword;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_vld_q;

    assign ra     = addrb[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd_acc = idle & enb[i];
    assign rword  = (wr_en && (ra == addra)) ? wr_word_d : mem[ra];

    // Stage 1: array read, data held until the next accepted read.
    always_ff @(posedge clka or negedge reset) begin
      if (!reset) begin
        rd_vld_q  <= 1'b0;
        rd_data_q <= '0;
      end else begin
        rd_vld_q <= rd_acc;
        if (rd_acc) begin
          rd_data_q <= rword;
        end
      end
    end

    if (READ_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] out_q;
      logic                  out_vld_q;

      // Stage 2: optional output register.
      always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
          out_vld_q <= 1'b0;
          out_q     <= '0;
        end else begin
          out_vld_q <= rd_vld_q;
          if (rd_vld_q) begin
            out_q <= rd_data_q;
          end
        end
      end

      assign doutb[i*DATA_WIDTH +: DATA_WIDTH] = out_q;
      assign validb[i]                         = out_vld_q;
    end else begin : g_direct
      assign doutb[i*DATA_WIDTH +: DATA_WIDTH] = rd_data_q;
      assign validb[i]                         = rd_vld_q;
    end
  end

endmodule

// File: tb/tb_clause_mem_banked.sv
// Directed bench for clause_mem_banked: two instances (latency 1 and 2) share
// one stimulus stream, 16-word array, two read channels.
module tb_clause_mem_banked;
  localparam int AW = 4;
  localparam int DW = 256;
  localparam int SW = 32;
  localparam int NR = 2;
  localparam int NS = DW / SW;

  logic clka = 1'b0;
  logic reset = 1'b0;
  logic clr_req = 1'b0;
  logic ena = 1'b0;
  logic wea = 1'b0;
  logic [AW-1:0] addra = '0;
  logic [DW-1:0] dina = '0;
  logic [NS-1:0] wmask = '0;
  logic [NR-1:0] enb = '0;
  logic [NR*AW-1:0] addrb = '0;

  logic clr_busy0, clr_busy1;
  logic [NR*DW-1:0] doutb0, doutb1;
  logic [NR-1:0] validb0, validb1;

  int total = 0;
  int bad = 0;

  always #5 clka = ~clka;

  clause_mem_banked #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEG_WIDTH(SW), .NUM_RD(NR),
                      .READ_REG(0), .INIT_ON_RESET(1)) u_lat1 (
    .clka(clka), .reset(reset), .clr_req(clr_req), .clr_busy(clr_busy0),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .wmask(wmask),
    .enb(enb), .addrb(addrb), .doutb(doutb0), .validb(validb0));

  clause_mem_banked #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEG_WIDTH(SW), .NUM_RD(NR),
                      .READ_REG(1), .INIT_ON_RESET(1)) u_lat2 (
    .clka(clka), .reset(reset), .clr_req(clr_req), .clr_busy(clr_busy1),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .wmask(wmask),
    .enb(enb), .addrb(addrb), .doutb(doutb1), .validb(validb1));

  function automatic logic [DW-1:0] pat(input int i);
    return {8{32'hC0DE0000 | 32'(i)}};
  endfunction

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NS-1:0] m);
    @(negedge clka);
    ena = 1'b1; wea = 1'b1; addra = a; dina = d; wmask = m;
    @(negedge clka);
    ena = 1'b0; wea = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [1:0] en,
                    output logic [1:0] v0, output logic [NR*DW-1:0] q0,
                    output logic [1:0] v1, output logic [NR*DW-1:0] q1);
    @(negedge clka);
    enb = en; addrb = {a1, a0};
    @(negedge clka);
    enb = '0;
    v0 = validb0; q0 = doutb0;
    @(negedge clka);
    v1 = validb1; q1 = doutb1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clka);
      if (clr_busy0 && clr_busy1) n++;
      else if (n > 0) break;
    end
  endtask

  task automatic test_reset();
    int n;
    repeat (2) @(negedge clka);
    total++;
    if ({clr_busy0, clr_busy1, validb0, validb1} !== 6'b0 || doutb0 !== '0 || doutb1 !== '0) begin
      bad++;
      $display("FAIL reset_state: busy=%b%b valid=%b/%b want all zero", clr_busy0, clr_busy1, validb0, validb1);
    end
    reset = 1'b1;
    count_busy(n);
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL init_clear_len: busy cycles=%0d want 16", n);
    end
  endtask

  task automatic test_clear_zero();
    logic [1:0] v0, v1;
    logic [NR*DW-1:0] q0, q1;
    for (int a = 0; a < 16; a++) begin
      rd(AW'(a), AW'(15 - a), 2'b11, v0, q0, v1, q1);
      total++;
      if (v0 !== 2'b11 || q0 !== '0 || v1 !== 2'b11 || q1 !== '0) begin
        bad++;
        $display("FAIL init_read_zero a=%0d: valid=%b/%b q0=%h want 11/11 zero", a, v0, v1, q0);
      end
    end
  endtask

  task automatic test_masked_write();
    logic [1:0] v0, v1;
    logic [NR*DW-1:0] q0, q1;
    logic [DW-1:0] exp;
    exp = {8{32'hA5A5A5A5}};
    exp[31:0] = 32'hFFFFFFFF;
    wr(4'd5, {8{32'hA5A5A5A5}}, 8'hFF);
    wr(4'd5, '1, 8'h01);
    rd(4'd5, 4'd5, 2'b11, v0, q0, v1, q1);
    total++;
    if (v0 !== 2'b11 || q0 !== {exp, exp}) begin
      bad++;
      $display("FAIL masked_write_lat1: valid=%b q=%h want 11 %h", v0, q0[DW-1:0], exp);
    end
    total++;
    if (v1 !== 2'b11 || q1 !== {exp, exp}) begin
      bad++;
      $display("FAIL masked_write_lat2: valid=%b q=%h want 11 %h", v1, q1[DW-1:0], exp);
    end
    wr(4'd5, '0, 8'h00);
    rd(4'd5, 4'd0, 2'b01, v0, q0, v1, q1);
    total++;
    if (v0 !== 2'b01 || q0[DW-1:0] !== exp) begin
      bad++;
      $display("FAIL zero_mask_noop: valid=%b q=%h want 01 %h", v0, q0[DW-1:0], exp);
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] exp5;
    exp5 = {8{32'hA5A5A5A5}};
    exp5[31:0] = 32'hFFFFFFFF;
    exp5[63:32] = 32'h11111111;
    @(negedge clka);
    ena = 1'b1; wea = 1'b1; addra = 4'd3; dina = 256'h1234; wmask = '1;
    enb = 2'b11; addrb = {4'd3, 4'd3};
    @(negedge clka);
    ena = 1'b0; wea = 1'b0; enb = '0;
    total++;
    if (validb0 !== 2'b11 || doutb0 !== {256'h1234, 256'h1234} || validb1 !== 2'b00) begin
      bad++;
      $display("FAIL collision_lat1: valid=%b/%b q=%h want 11/00 1234", validb0, validb1, doutb0[DW-1:0]);
    end
    @(negedge clka);
    total++;
    if (validb1 !== 2'b11 || doutb1 !== {256'h1234, 256'h1234} || validb0 !== 2'b00) begin
      bad++;
      $display("FAIL collision_lat2: valid=%b/%b q=%h want 00/11 1234", validb0, validb1, doutb1[DW-1:0]);
    end
    @(negedge clka);
    ena = 1'b1; wea = 1'b1; addra = 4'd5; dina = {8{32'h11111111}}; wmask = 8'h02;
    enb = 2'b11; addrb = {4'd3, 4'd5};
    @(negedge clka);
    ena = 1'b0; wea = 1'b0; enb = '0;
    total++;
    if (validb0 !== 2'b11 || doutb0 !== {256'h1234, exp5}) begin
      bad++;
      $display("FAIL collision_masked: valid=%b q=%h want 11 %h", validb0, doutb0[DW-1:0], exp5);
    end
    @(negedge clka);
  endtask

  task automatic test_back_to_back();
    int errs;
    for (int i = 0; i < 8; i++) wr(AW'(i), pat(i), '1);
    errs = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clka);
      if (validb0 !== {1'b0, (cyc >= 1 && cyc <= 8)}) errs++;
      else if (cyc >= 1 && cyc <= 8 && doutb0[DW-1:0] !== pat(cyc - 1)) errs++;
      if (validb1 !== {1'b0, (cyc >= 2 && cyc <= 9)}) errs++;
      else if (cyc >= 2 && cyc <= 9 && doutb1[DW-1:0] !== pat(cyc - 2)) errs++;
      if (cyc < 8) begin
        enb = 2'b01; addrb = {4'd0, AW'(cyc)};
      end else begin
        enb = '0;
      end
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL stream_reads: %0d cycle errors want 0", errs);
    end
    total++;
    if (doutb0[DW-1:0] !== pat(7) || doutb1[DW-1:0] !== pat(7)) begin
      bad++;
      $display("FAIL stream_hold: q=%h/%h want %h", doutb0[DW-1:0], doutb1[DW-1:0], pat(7));
    end
  endtask

  task automatic test_clr_req();
    int n;
    int vbad;
    logic [1:0] v0, v1;
    logic [NR*DW-1:0] q0, q1;
    wr(4'd9, pat(9), '1);
    wr(4'd12, pat(12), '1);
    @(negedge clka);
    clr_req = 1'b1;
    @(negedge clka);
    clr_req = 1'b0;
    n = 0;
    vbad = 0;
    for (int c = 0; c < 100; c++) begin
      if (!(clr_busy0 && clr_busy1)) break;
      n++;
      if (validb0 !== 2'b00 || validb1 !== 2'b00) vbad++;
      clr_req = (n == 3);
      ena = (n == 5); wea = (n == 5); addra = 4'd2; dina = '1; wmask = '1;
      enb = (n == 7) ? 2'b11 : 2'b00; addrb = {4'd12, 4'd9};
      @(negedge clka);
    end
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL clr_req_len: busy cycles=%0d want 16", n);
    end
    total++;
    if (vbad != 0) begin
      bad++;
      $display("FAIL clr_no_valid: %0d cycles with valid during clear want 0", vbad);
    end
    enb = 2'b11; addrb = {4'd9, 4'd2};
    @(negedge clka);
    enb = '0;
    total++;
    if (validb0 !== 2'b11 || doutb0 !== '0) begin
      bad++;
      $display("FAIL first_idle_read: valid=%b q=%h want 11 zero", validb0, doutb0[DW-1:0]);
    end
    @(negedge clka);
    for (int a = 0; a < 16; a += 2) begin
      rd(AW'(a), AW'(a + 1), 2'b11, v0, q0, v1, q1);
      total++;
      if (v0 !== 2'b11 || q0 !== '0 || v1 !== 2'b11 || q1 !== '0) begin
        bad++;
        $display("FAIL clr_read_zero a=%0d: valid=%b/%b q=%h want 11/11 zero", a, v0, v1, q0);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    logic [1:0] v0, v1;
    logic [NR*DW-1:0] q0, q1;
    wr(4'd9, pat(9), '1);
    rd(4'd9, 4'd9, 2'b11, v0, q0, v1, q1);
    total++;
    if (q0 !== {pat(9), pat(9)} || q1 !== {pat(9), pat(9)}) begin
      bad++;
      $display("FAIL pre_reset_read: q=%h want %h", q0[DW-1:0], pat(9));
    end
    @(negedge clka);
    clr_req = 1'b1;
    @(negedge clka);
    clr_req = 1'b0;
    n = 1;
    while (n < 7 && clr_busy0) begin
      @(negedge clka);
      n++;
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({clr_busy0, clr_busy1, validb0, validb1} !== 6'b0 || doutb0 !== '0 || doutb1 !== '0) begin
      bad++;
      $display("FAIL async_reset: busy=%b%b q=%h want all zero", clr_busy0, clr_busy1, doutb0[DW-1:0]);
    end
    @(negedge clka);
    reset = 1'b1;
    count_busy(n);
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL restart_clear_len: busy cycles=%0d want 16", n);
    end
    wr(4'd12, pat(12), '1);
    rd(4'd9, 4'd12, 2'b11, v0, q0, v1, q1);
    total++;
    if (v0 !== 2'b11 || q0 !== {pat(12), 256'h0}) begin
      bad++;
      $display("FAIL post_restart_read: q=%h want %h", q0, {pat(12), 256'h0});
    end
  endtask

  initial begin
    test_reset();
    test_clear_zero();
    test_masked_write();
    test_collision();
    test_back_to_back();
    test_clr_req();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish want finish");
    $fatal(1, "timeout");
  end

endmodule
